// File: rtl/s_fold_pkg.sv
// s_fold_pkg: shared widths, beat indices and output-slot states for the XOR fold front end
package s_fold_pkg;
    localparam int HALF_W = 16;
    localparam int WORD_W = 2 * HALF_W;
    localparam logic [1:0] BEAT_ALO = 2'd0;
    localparam logic [1:0] BEAT_AHI = 2'd1;
    localparam logic [1:0] BEAT_BLO = 2'd2;
    localparam logic [1:0] BEAT_BHI = 2'd3;
    typedef enum logic {EMPTY, FULL} slot_state_e;
endpackage

// File: rtl/s_pair_slot.sv
// s_pair_slot: registered valid/ready holding slot for an a/b word pair plus delivered-pair counter
module s_pair_slot
    import s_fold_pkg::*;
#(
    parameter int W = WORD_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_a,
    input  logic [W-1:0] load_b,
    input  logic         out_ready,
    output logic [W-1:0] a,
    output logic [W-1:0] b,
    output logic         out_valid,
    output logic [7:0]   pair_cnt
);
    slot_state_e state_q, state_d;
    logic [W-1:0] a_q, a_d, b_q, b_d;
    logic [7:0] cnt_q, cnt_d;
    logic hs;

    // a completion arriving in the same cycle as a drain wins and keeps the slot full
    always_comb begin
        hs = (state_q == FULL) && out_ready;
        state_d = load ? FULL : hs ? EMPTY : state_q;
        a_d = load ? load_a : a_q;
        b_d = load ? load_b : b_q;
        cnt_d = hs ? cnt_q + 8'd1 : cnt_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= EMPTY;
            a_q <= '0;
            b_q <= '0;
            cnt_q <= '0;
        end else begin
            state_q <= state_d;
            a_q <= a_d;
            b_q <= b_d;
            cnt_q <= cnt_d;
        end
    end

    assign a = a_q;
    assign b = b_q;
    assign out_valid = (state_q == FULL);
    assign pair_cnt = cnt_q;
endmodule

// File: rtl/s_pair_loader.sv
// s_pair_loader: gathers four half-word beats into an a/b word pair and hands it to an output slot
module s_pair_loader #(
    parameter int HALF_W    = s_fold_pkg::HALF_W,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [HALF_W-1:0]   in_data,
    input  logic                in_valid,
    input  logic                in_sof,
    output logic                in_ready,
    output logic [2*HALF_W-1:0] a,
    output logic [2*HALF_W-1:0] b,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                sync_err,
    output logic [7:0]          pair_cnt
);
    import s_fold_pkg::*;
    localparam int WW = 2 * HALF_W;

    logic rdy_q, rdy_d, err_q, err_d, acc, sof_err, hi, load, out_valid_w;
    logic [1:0] cnt_q, cnt_d, idx;
    logic [WW-1:0] asm_a_q, asm_a_d, asm_b_q, asm_b_d, base_a, base_b;

    // an sof beat mid-pair drops the partial pair and restarts at beat 0
    always_comb begin
        rdy_d = 1'b1;
        in_ready = rdy_q && (cnt_q != BEAT_BHI || !out_valid_w || out_ready);
        acc = in_valid && in_ready;
        sof_err = acc && in_sof && cnt_q != BEAT_ALO;
        idx = (acc && in_sof) ? BEAT_ALO : cnt_q;
        hi = idx[0] ~^ LSB_FIRST;
        base_a = sof_err ? '0 : asm_a_q;
        base_b = sof_err ? '0 : asm_b_q;
        asm_a_d = (acc && !idx[1]) ? (hi ? {in_data, base_a[HALF_W-1:0]} : {base_a[WW-1:HALF_W], in_data}) : base_a;
        asm_b_d = (acc && idx[1]) ? (hi ? {in_data, base_b[HALF_W-1:0]} : {base_b[WW-1:HALF_W], in_data}) : base_b;
        load = acc && idx == BEAT_BHI;
        cnt_d = acc ? idx + 2'd1 : cnt_q;
        err_d = err_q || sof_err;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdy_q <= 1'b0;
            err_q <= 1'b0;
            cnt_q <= '0;
            asm_a_q <= '0;
            asm_b_q <= '0;
        end else begin
            rdy_q <= rdy_d;
            err_q <= err_d;
            cnt_q <= cnt_d;
            asm_a_q <= asm_a_d;
            asm_b_q <= asm_b_d;
        end
    end

    s_pair_slot #(.W(WW)) u_slot (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .load_a    (asm_a_d),
        .load_b    (asm_b_d),
        .out_ready (out_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid_w),
        .pair_cnt  (pair_cnt)
    );

    assign out_valid = out_valid_w;
    assign sync_err = err_q;
endmodule

// File: doc/s_pair_loader.md
Name: s_pair_loader

Overview:
- Upstream feeder for the 32-bit XOR fold stage (a/b -> aa/bb).
- Takes a 16-bit half-word stream on a valid/ready handshake and assembles four beats into one 32-bit word pair (a, b).
- Presents each completed pair from a registered output slot on its own valid/ready handshake, so the combinational fold stage sees stable operands.

Parameters:
- HALF_W, 16, half-word width; a and b are 2*HALF_W wide.
- LSB_FIRST, 1, 1: low half of each word arrives first; 0: high half first.

Ports:
- clk  input  1  single clock, rising edge
- rst  input  1  asynchronous, active-high reset
- in_data  input  HALF_W  half-word beat
- in_valid  input  1  beat valid
- in_sof  input  1  start-of-frame; qualifies with in_valid, marks beat 0 of a pair
- in_ready  output  1  beat accepted when in_valid && in_ready
- a  output  2*HALF_W  assembled word A to the fold stage
- b  output  2*HALF_W  assembled word B to the fold stage
- out_valid  output  1  a/b pair valid
- out_ready  input  1  downstream accepts the pair
- sync_err  output  1  sticky framing-error flag
- pair_cnt  output  8  count of pairs delivered, wraps 255->0

Behaviour:
- Reset, asynchronous: beat counter=0, assembly regs=0, a=b=0, out_valid=0, sync_err=0, pair_cnt=0. in_ready=1 one cycle after reset release.
- Beat order with LSB_FIRST=1: beat0 a[15:0], beat1 a[31:16], beat2 b[15:0], beat3 b[31:16]. LSB_FIRST=0 swaps the halves within each word.
- Beat counter 0..3 advances only on an accepted beat and wraps 3->0 on completion.
- Assembly regs are separate from the output slot. Beats 0-2 are always accepted (in_ready=1).
- Beat 3: in_ready = !out_valid || out_ready, so no bubble when downstream drains in the same cycle.
- Completion: the cycle after beat 3 is accepted, a/b are loaded with the full pair and out_valid=1. Latency from last beat to out_valid is 1 cycle.
- out_valid holds, and a/b are stable, until out_valid && out_ready. It then drops unless a new completion loads in the same cycle; that load takes priority and out_valid stays 1.
- pair_cnt increments on each out_valid && out_ready.
- Framing, accepted beat with in_sof=1:
  - counter==0: normal.
  - counter!=0: partial pair discarded, sync_err set, the beat is taken as beat0, counter -> 1.
- Framing, accepted beat with in_sof=0 and counter==0: accepted as beat0, no error.
- sync_err clears only on rst.
- Output state machine has two states, EMPTY and FULL.
  - EMPTY -> FULL on completion.
  - FULL -> EMPTY on handshake without completion.
  - FULL -> FULL on handshake with completion, or on no handshake.
- in_data, in_sof are ignored when in_valid=0. out_ready is ignored when out_valid=0.
- Reset mid-assembly or mid-output drops all state; no pair is emitted.

Decomposition:
- Shared package s_fold_pkg holds:
  - HALF_W default and WORD_W = 2*HALF_W.
  - Beat-index constants BEAT_ALO, BEAT_AHI, BEAT_BLO, BEAT_BHI.
  - Output-state enum {EMPTY, FULL}.
- One sub-module, s_pair_slot: the output register slot (valid/ready holding register for a/b plus the pair_cnt counter).
- Beat counter and assembly stay in the top module.

Test Plan:
- Reset, 4 beats 0x1111, 0x2222, 0x3333, 0x4444 (sof on first), out_ready=1 -> one cycle after beat 4: a=0x22221111, b=0x44443333, out_valid=1, pair_cnt=1 after handshake.
- Back-to-back pairs, in_valid and out_ready held 1 for 12 beats -> 3 pairs, in_ready never drops, out_valid contiguous after first fill, pair_cnt=3.
- Backpressure: out_ready=0 with one pair held, stream 4 more beats -> beats 0-2 accepted, in_ready=0 on beat 3. Raise out_ready -> beat 3 accepted the same cycle, second pair appears the next cycle, first pair unchanged until its handshake.
- Framing error: beats 0xAAAA, 0xBBBB, then in_sof=1 with 0x0001, 0x0002, 0x0003, 0x0004 -> sync_err=1, emitted a=0x00020001, b=0x00040003, no pair containing 0xAAAA.
- LSB_FIRST=0 instance, beats 0x1111, 0x2222, 0x3333, 0x4444 -> a=0x11112222, b=0x33334444.
- Assert rst after 2 beats and while out_valid=1 -> all outputs return to reset values asynchronously (before the next clk edge). A fresh 4-beat pair afterwards is assembled correctly, and sync_err=0.
